// File: rtl/gaussian_blur.sv
// gaussian_blur: streaming 3x3 1-2-1/2-4-2/1-2-1 RGB blur, one result per nine-beat window.
// Optional macro GAUSS_ROUND_EN selects round-half-up instead of truncation.
module gaussian_blur (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        i_rgb_busy,
  input  logic        i_rgb_vld,
  input  logic [24:0] i_rgb_data,
  input  logic        o_result_busy,
  output logic        o_result_vld,
  output logic [31:0] o_result_data
);
  typedef enum logic [1:0] {RST, COLLECT, OUTPUT} state_t;
`ifdef GAUSS_ROUND_EN
  localparam logic [11:0] RND = 12'd8;
`else
  localparam logic [11:0] RND = 12'd0;
`endif
  state_t state, state_nxt;
  logic [3:0] cnt, idx;
  logic [1:0] sh;
  logic [2:0][11:0] acc, acc_nxt;
  logic [23:0] res;
  logic accept, last;
  always_comb begin
    idx = i_rgb_data[24] ? 4'd0 : cnt;
    sh = idx == 4'd4 ? 2'd2 : {1'b0, idx[0]};
    accept = state == COLLECT && i_rgb_vld;
    last = accept && idx == 4'd8;
    acc_nxt = '0;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      acc_nxt[c] = (idx == 4'd0 ? 12'd0 : acc[c]) + (12'(i_rgb_data[8*c +: 8]) << sh);
      res[8*c +: 8] = 8'((acc_nxt[c] + RND) >> 4);
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      RST:     state_nxt = COLLECT;
      COLLECT: state_nxt = last ? OUTPUT : COLLECT;
      default: state_nxt = o_result_busy ? OUTPUT : COLLECT;
    endcase
  end
  always_comb begin
    i_rgb_busy = state != COLLECT;
    o_result_vld = state == OUTPUT;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RST;
      cnt <= '0;
      acc <= '0;
      o_result_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= last ? '0 : acc_nxt;
        cnt <= last ? 4'd0 : 4'(idx + 4'd1);
      end
      if (last) o_result_data <= {8'd0, res};
    end
  end
endmodule

// File: tb/tb_gaussian_blur.sv
// tb_gaussian_blur: directed scoreboard bench for gaussian_blur.
module tb_gaussian_blur;
  logic i_clk = 0, i_rst = 1, i_rgb_vld = 0, o_result_busy = 0;
  logic [24:0] i_rgb_data = '0;
  logic i_rgb_busy, o_result_vld;
  logic [31:0] o_result_data;
  int tests = 0, fails = 0;
  logic [31:0] sb[$];
  logic [23:0] win[9];

  always #5 i_clk = ~i_clk;

  gaussian_blur dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rgb_busy(i_rgb_busy), .i_rgb_vld(i_rgb_vld),
    .i_rgb_data(i_rgb_data), .o_result_busy(o_result_busy), .o_result_vld(o_result_vld),
    .o_result_data(o_result_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model();
    int w[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    logic [31:0] r = '0;
    for (int c = 0; c < 3; c++) begin
      int a = 0;
      for (int k = 0; k < 9; k++) a += w[k] * int'(win[k][8*c +: 8]);
`ifdef GAUSS_ROUND_EN
      a += 8;
`endif
      r[8*c +: 8] = 8'(a >> 4);
    end
    return r;
  endfunction

  task automatic send_beat(input logic [24:0] d);
    bit done = 0;
    logic b;
    @(negedge i_clk);
    i_rgb_vld = 1;
    i_rgb_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      b = i_rgb_busy;
      @(posedge i_clk);
      if (!b) done = 1;
      else @(negedge i_clk);
    end
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic send_window(input bit flag, input logic [31:0] exp);
    sb.push_back(exp);
    for (int k = 0; k < 9; k++) send_beat({flag && k == 0, win[k]});
    @(negedge i_clk);
    i_rgb_vld = 0;
    check("latency_vld", o_result_vld, 1);
  endtask

  task automatic take_result(input string tag);
    int n = 0;
    logic [31:0] exp;
    while (!o_result_vld && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_vld"}, o_result_vld, 1);
    exp = sb.size() != 0 ? sb.pop_front() : 32'hxxxxxxxx;
    check(tag, o_result_data, exp);
    o_result_busy = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    check({tag, "_post_vld"}, o_result_vld, 0);
    check({tag, "_post_busy"}, i_rgb_busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_vld", o_result_vld, 0);
    check("rst_busy", i_rgb_busy, 1);
    check("rst_data", o_result_data, 0);
    i_rst = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rst_release_busy", i_rgb_busy, 0);

    for (int k = 0; k < 9; k++) win[k] = 24'h804020;
    send_window(1, 32'h00804020);
    take_result("uniform");

    for (int k = 0; k < 9; k++) win[k] = k == 4 ? 24'h0000FF : 24'h0;
`ifdef GAUSS_ROUND_EN
    send_window(0, 32'h00000040);
`else
    send_window(0, 32'h0000003F);
`endif
    take_result("impulse");

    for (int k = 0; k < 9; k++) win[k] = 24'($urandom);
    o_result_busy = 1;
    send_window(1, model());
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", o_result_vld, 1);
      check("bp_busy", i_rgb_busy, 1);
      check("bp_data", o_result_data, sb[0]);
      @(negedge i_clk);
    end
    take_result("backpressure");

    for (int k = 0; k < 4; k++) send_beat(25'h0FFFFFF);
    @(negedge i_clk);
    i_rgb_vld = 0;
    check("resync_no_vld", o_result_vld, 0);
    for (int k = 0; k < 9; k++) win[k] = 24'h101010;
    send_window(1, 32'h00101010);
    take_result("resync");

    for (int k = 0; k < 5; k++) send_beat(25'h0ABCDEF);
    @(negedge i_clk);
    i_rgb_vld = 0;
    i_rst = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("midrst_vld", o_result_vld, 0);
    check("midrst_busy", i_rgb_busy, 1);
    i_rst = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("midrst_release_busy", i_rgb_busy, 0);
    for (int k = 0; k < 9; k++) win[k] = 24'h000010;
    send_window(0, 32'h00000010);
    take_result("after_reset");

    for (int k = 0; k < 9; k++) win[k] = 24'hFFFFFF;
    send_window(1, 32'h00FFFFFF);
    take_result("max");

    for (int k = 0; k < 9; k++) win[k] = 24'($urandom);
    send_window(1, model());
    take_result("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gaussian_blur.md
Name: gaussian_blur

Overview:
- Streaming 3x3 Gaussian blur kernel for the Stratus-generated image filter accelerator.
- Accepts the nine RGB pixels of one 3x3 window, one per handshake beat.
- Computes one blurred RGB pixel per window using the 1-2-1 / 2-4-2 / 1-2-1 kernel divided by 16.
- Returns the result on a busy/valid output channel. Sits between the pixel-fetch DMA/testbench source and the result sink.

Parameters:
- none. Kernel weights fixed: 1,2,1,2,4,2,1,2,1. Divisor fixed at 16.

Ports:
- i_clk  input  1  single system clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rgb_busy  output  1  high = block cannot accept an input beat this cycle.
- i_rgb_vld  input  1  input beat valid.
- i_rgb_data  input  25  [7:0]=R, [15:8]=G, [23:16]=B, [24]=window-start flag.
- o_result_busy  input  1  high = sink cannot accept a result this cycle.
- o_result_vld  output  1  result valid.
- o_result_data  output  32  [7:0]=R, [15:8]=G, [23:16]=B blurred; [31:24]=0.

Behaviour:
- Handshake (both channels): a transfer occurs on a rising edge where vld=1 and busy=0. The producer holds vld and data stable until the transfer.
- Reset (i_rst=1 at an edge):
  - o_result_vld=0, o_result_data=0, i_rgb_busy=1.
  - Pixel count=0; accumulators cleared.
  - i_rgb_busy drops to 0 on the first cycle after i_rst is deasserted.
  - Reset mid-window or with a pending result discards all partial state and the pending result.
- States:
  - COLLECT: i_rgb_busy=0, o_result_vld=0.
  - OUTPUT: i_rgb_busy=1, o_result_vld=1.
- COLLECT, on each accepted beat with index k (0..8):
  - Each channel accumulator += w[k]*pixel, with w = {1,2,1,2,4,2,1,2,1} in raster order (top row left to right, then middle, then bottom).
  - Window-start flag: if bit 24=1, the beat is forced to index 0 and the accumulators are loaded with w[0]*pixel, discarding any partial window. Bit 24=0 on the beat at index 0 is still accepted as index 0.
  - After the index-8 beat: compute the result, register it into o_result_data, set o_result_vld=1, enter OUTPUT.
  - Latency: o_result_vld is high on the cycle immediately after the 9th transfer.
- Arithmetic:
  - Accumulators are 12 bits unsigned per channel; maximum 16*255=4080, so no overflow.
  - Result = accumulator>>4 (truncate), giving 8 bits that never exceed 255.
- OUTPUT:
  - o_result_data is held stable while o_result_busy=1.
  - When o_result_busy=0, the transfer occurs at that edge. The block then clears o_result_vld, resets count and accumulators, and returns to COLLECT, with i_rgb_busy=0 on the next cycle.
  - Input beats are never accepted in OUTPUT, so a simultaneous input vld is simply stalled.
- Throughput: 9 input cycles + 1 output cycle per window, minimum 10 cycles per result.
- The upper output byte is always 0.

Optional Feature:
- Macro GAUSS_ROUND_EN.
  - Defined: result = (acc+8)>>4 per channel, i.e. round half up. Maximum (4080+8)>>4 = 255, so still no saturation is needed.
  - Undefined: truncation (acc>>4).
- All other behaviour is identical.

Test Plan:
- Uniform window: 9 beats of 0x0804020 (bit24=1 on the first) -> one result 0x00804020, o_result_vld high the cycle after the 9th beat.
- Centre impulse: only beat 4 = 0x00000FF, others 0 -> 0x0000003F (truncate); 0x00000040 with GAUSS_ROUND_EN.
- Output backpressure: hold o_result_busy=1 for 5 cycles after the result appears -> o_result_data stable, o_result_vld=1, i_rgb_busy=1 throughout; transfer on the first cycle with busy=0, then i_rgb_busy=0.
- Resync: send 4 beats of 0x0FFFFFF, then 9 beats of 0x0101010 with bit24=1 on the first of them -> single result 0x00101010.
- Reset mid-window: 5 beats accepted, pulse i_rst one cycle -> o_result_vld=0, i_rgb_busy=1 during reset; then a full window of 0x0000010 -> result 0x00000010.
- Max value: 9 beats of 0x0FFFFFF -> 0x00FFFFFF in both rounding modes; no overflow.
